// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: accepts one CPU word access at a time, decodes it
// to on-chip RAM (programmable wait states) or the peripheral port (req/ack
// with timeout), and completes it with a one-cycle mio_ready pulse.
module mio_bus_responder #(
    parameter int ADDR_W      = 10,
    parameter int RAM_WAIT    = 1,
    parameter int PER_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mio,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              mio_ready,
    output logic              bus_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              per_req,
    output logic              per_we,
    output logic [7:0]        per_addr,
    output logic [31:0]       per_wdata,
    input  logic              per_ack,
    input  logic [31:0]       per_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_ACC = 2'd1,
        PER_REQ = 2'd2,
        DONE    = 2'd3
    } state_t;

    // One counter serves both the RAM wait states and the peripheral timeout.
    localparam logic [7:0] RAM_CNT = 8'(RAM_WAIT);
    localparam logic [7:0] PER_CNT = 8'(PER_TIMEOUT);

    state_t            state_q,    state_d;
    logic [7:0]        cnt_q,      cnt_d;
    logic              we_q,       we_d;
    logic              err_q,      err_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        per_addr_q, per_addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [31:0]       rdata_q,    rdata_d;

    // Only some address bits are latched; the rest are don't-care by design.
    logic unused_addr;
    assign unused_addr = ^addr;

    // State and latched-request registers; reset aborts any access at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            ram_addr_q <= '0;
            per_addr_q <= 8'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            err_q      <= err_d;
            ram_addr_q <= ram_addr_d;
            per_addr_q <= per_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state logic: accept/decode in IDLE, count down in the access states.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        err_d      = err_q;
        ram_addr_d = ram_addr_q;
        per_addr_d = per_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_mio && (mem_read || mem_write)) begin
                    we_d       = mem_write;
                    wdata_d    = cpu_wdata;
                    ram_addr_d = addr[ADDR_W+1:2];
                    per_addr_d = addr[9:2];
                    err_d      = 1'b0;
                    // Illegal direction or misaligned address: answer with an
                    // error without touching RAM or the peripheral.
                    if ((mem_read && mem_write) || (addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (addr[31:28] == 4'hF) begin
                        cnt_d   = PER_CNT;
                        state_d = PER_REQ;
                    end else begin
                        cnt_d   = RAM_CNT;
                        state_d = RAM_ACC;
                    end
                end
            end
            RAM_ACC: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = ram_rdata;
                    end
                    state_d = DONE;
                end
            end
            PER_REQ: begin
                // An ack in the final counted cycle still wins over the timeout.
                if (per_ack) begin
                    if (!we_q) begin
                        rdata_d = per_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from state and latched registers only.
    assign mio_ready = (state_q == DONE);
    assign bus_err   = (state_q == DONE) && err_q;
    assign cpu_rdata = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = wdata_q;
    // The counter still holds its load value only in the first RAM_ACC cycle.
    assign ram_we    = (state_q == RAM_ACC) && we_q && (cnt_q == RAM_CNT);
    assign per_req   = (state_q == PER_REQ);
    assign per_we    = we_q;
    assign per_addr  = per_addr_q;
    assign per_wdata = wdata_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: vector table with a scoreboard queue, a RAM
// model, a peripheral ack model and hand-written reset/ignore sequences.
module tb_mio_bus_responder;

    localparam int ADDR_W = 10;
    localparam int K_RAM  = 0;
    localparam int K_PER  = 1;
    localparam int K_ERR  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_mio, mem_read, mem_write;
    logic [31:0]       addr, cpu_wdata, cpu_rdata;
    logic              mio_ready, bus_err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata, ram_rdata;
    logic              per_req, per_we;
    logic [7:0]        per_addr;
    logic [31:0]       per_wdata;
    logic              per_ack;
    logic [31:0]       per_rdata;

    logic [31:0] ram_mem [0:(1<<ADDR_W)-1];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          ack_dly;   // 0 = peripheral never acks
        logic [31:0] prd;
        int          kind;
        logic [31:0] loc;       // expected ram_addr or per_addr
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          we_cnt;
        int          req_cnt;
    } vec_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          we_cnt;
        int          req_cnt;
    } exp_t;

    vec_t vecs [13];
    exp_t sbq [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mio_bus_responder #(.ADDR_W(ADDR_W), .RAM_WAIT(1), .PER_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio), .mem_read(mem_read),
        .mem_write(mem_write), .addr(addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .mio_ready(mio_ready), .bus_err(bus_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .per_req(per_req), .per_we(per_we),
        .per_addr(per_addr), .per_wdata(per_wdata), .per_ack(per_ack),
        .per_rdata(per_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cyc, nwe, nreq;
        bit   done;
        e.lat = v.lat; e.err = v.err; e.rdata = v.rdata;
        e.we_cnt = v.we_cnt; e.req_cnt = v.req_cnt;
        sbq.push_back(e);
        @(negedge clk);
        cpu_mio = 1'b1; mem_read = v.rd; mem_write = v.wr;
        addr = v.a; cpu_wdata = v.wd;
        cyc = 0; nwe = 0; nreq = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            per_ack = 1'b0;
            if (ram_we) begin
                nwe++;
                chk("ram_wdata", ram_wdata, v.wd);
                chk("ram_addr_at_we", 32'(ram_addr), v.loc);
            end
            if (per_req) begin
                nreq++;
                if (v.ack_dly != 0 && nreq == v.ack_dly) begin
                    per_ack = 1'b1;
                    per_rdata = v.prd;
                end
            end
            if (mio_ready) done = 1'b1;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL mio_ready_timeout: got no mio_ready in %0d cycles, expected one by %0d", cyc, v.lat);
        end
        e = sbq.pop_front();
        chk("latency", 32'(cyc), 32'(e.lat));
        chk("bus_err", 32'(bus_err), 32'(e.err));
        chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("ram_we_cycles", 32'(nwe), 32'(e.we_cnt));
        chk("per_req_cycles", 32'(nreq), 32'(e.req_cnt));
        if (v.kind == K_RAM) chk("ram_addr", 32'(ram_addr), v.loc);
        if (v.kind == K_PER) begin
            chk("per_addr", 32'(per_addr), v.loc);
            chk("per_we", 32'(per_we), 32'(v.wr));
            if (v.wr) chk("per_wdata", per_wdata, v.wd);
        end
        cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        chk("mio_ready_one_cycle", 32'(mio_ready), 32'd0);
    endtask

    initial begin
        int nbad;
        for (int i = 0; i < (1<<ADDR_W); i++) ram_mem[i] = 32'd0;
        ram_mem[4]    = 32'h1234_5678;
        ram_mem[1023] = 32'hDEAD_BEEF;

        //            rd wr addr           wdata          ack prdata         kind   loc     lat err rdata          we req
        vecs[0]  = '{1, 0, 32'h0000_0010, 32'h0,         0,  32'h0,         K_RAM, 32'h4,   3, 0, 32'h1234_5678, 0, 0};
        vecs[1]  = '{0, 1, 32'h0000_0008, 32'hCAFE_F00D, 0,  32'h0,         K_RAM, 32'h2,   3, 0, 32'h1234_5678, 1, 0};
        vecs[2]  = '{1, 0, 32'h0000_0008, 32'h0,         0,  32'h0,         K_RAM, 32'h2,   3, 0, 32'hCAFE_F00D, 0, 0};
        vecs[3]  = '{1, 0, 32'hF000_0024, 32'h0,         4,  32'hA5A5_0001, K_PER, 32'h9,   5, 0, 32'hA5A5_0001, 0, 4};
        vecs[4]  = '{0, 1, 32'hF000_0040, 32'h1111_2222, 0,  32'h0,         K_PER, 32'h10, 17, 1, 32'hA5A5_0001, 0, 16};
        vecs[5]  = '{1, 1, 32'h0000_0020, 32'h0,         0,  32'h0,         K_ERR, 32'h0,   1, 1, 32'hA5A5_0001, 0, 0};
        vecs[6]  = '{1, 0, 32'h0000_0006, 32'h0,         0,  32'h0,         K_ERR, 32'h0,   1, 1, 32'hA5A5_0001, 0, 0};
        vecs[7]  = '{0, 1, 32'hF000_0002, 32'h5,         1,  32'h0,         K_ERR, 32'h0,   1, 1, 32'hA5A5_0001, 0, 0};
        vecs[8]  = '{1, 0, 32'hF000_0000, 32'h0,         16, 32'h5A5A_7777, K_PER, 32'h0,  17, 0, 32'h5A5A_7777, 0, 16};
        vecs[9]  = '{0, 1, 32'hF000_03FC, 32'h3,         1,  32'h0,         K_PER, 32'hFF,  2, 0, 32'h5A5A_7777, 0, 1};
        vecs[10] = '{1, 0, 32'h1000_0FFC, 32'h0,         0,  32'h0,         K_RAM, 32'h3FF, 3, 0, 32'hDEAD_BEEF, 0, 0};
        vecs[11] = '{0, 1, 32'h7000_0000, 32'h0102_0304, 0,  32'h0,         K_RAM, 32'h0,   3, 0, 32'hDEAD_BEEF, 1, 0};
        vecs[12] = '{1, 0, 32'h7000_0000, 32'h0,         0,  32'h0,         K_RAM, 32'h0,   3, 0, 32'h0102_0304, 0, 0};

        reset = 1'b1; cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = 32'd0; cpu_wdata = 32'd0; per_ack = 1'b0; per_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mio_ready", 32'(mio_ready), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_ram_we_per_req", {30'd0, ram_we, per_req}, 32'd0);
        chk("rst_addrs", {14'd0, per_addr, ram_addr}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Requests without cpu_mio and stray acks must be ignored.
        @(negedge clk);
        mem_read = 1'b1; addr = 32'h0000_0010; per_ack = 1'b1;
        nbad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mio_ready || ram_we || per_req) nbad++;
        end
        chk("ignored_request", 32'(nbad), 32'd0);
        mem_read = 1'b0; per_ack = 1'b0;

        // Reset in the middle of a peripheral access.
        @(negedge clk);
        cpu_mio = 1'b1; mem_read = 1'b1; addr = 32'hF000_0004;
        repeat (3) @(posedge clk);
        #1;
        chk("per_req_before_reset", 32'(per_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("per_req_async_drop", 32'(per_req), 32'd0);
        chk("mio_ready_in_reset", 32'(mio_ready), 32'd0);
        cpu_mio = 1'b0; mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        nbad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mio_ready || per_req) nbad++;
        end
        chk("no_ready_after_abort", 32'(nbad), 32'd0);
        chk("rdata_cleared_by_reset", cpu_rdata, 32'd0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO bus responder: the slave end of the CPU's memory handshake (cpu_mio, mem_read, mem_write, mio_ready).
- Accepts one CPU word access at a time and decodes it to on-chip RAM or the peripheral port.
- Performs the access with programmable wait states or a peripheral req/ack handshake.
- Returns read data and a single-cycle mio_ready completion pulse, with a bus-error flag.

Parameters:
ADDR_W, 10, RAM word-address width (RAM depth 2**ADDR_W words)
RAM_WAIT, 1, extra RAM access cycles beyond the first (0..15)
PER_TIMEOUT, 16, max cycles waiting for per_ack before error (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
cpu_mio  in  1  CPU drives a bus request this cycle
mem_read  in  1  read request, held by CPU until mio_ready
mem_write  in  1  write request, held by CPU until mio_ready
addr  in  32  byte address, word aligned
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid from mio_ready cycle
mio_ready  out  1  one-cycle completion pulse
bus_err  out  1  error qualifier, valid only with mio_ready
ram_addr  out  ADDR_W  RAM word address = latched addr[ADDR_W+1:2]
ram_we  out  1  RAM write strobe
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data (combinational from ram_addr)
per_req  out  1  peripheral request, held until ack or timeout
per_we  out  1  peripheral write (1) / read (0)
per_addr  out  8  latched addr[9:2]
per_wdata  out  32  peripheral write data
per_ack  in  1  peripheral completion
per_rdata  in  32  peripheral read data, valid with per_ack

Behaviour:
- Reset: state IDLE. All outputs 0, including cpu_rdata and counters. Reset mid-transaction aborts immediately; per_req and ram_we drop asynchronously and no mio_ready is issued.
- All outputs are registered or decoded from state/latched registers. No combinational path from CPU inputs to outputs.
- States: IDLE, RAM_ACC, PER_REQ, DONE.
- IDLE:
  - Accept when cpu_mio=1 and (mem_read | mem_write). Latch addr, cpu_wdata and direction (we = mem_write).
  - Both mem_read and mem_write set: illegal. Go to DONE with err=1; no RAM/peripheral access.
  - addr[31:28]==4'hF: go to PER_REQ, timeout counter = PER_TIMEOUT.
  - Otherwise: go to RAM_ACC, wait counter = RAM_WAIT.
  - addr[1:0]!=0: error; go to DONE with err=1, no access.
- RAM_ACC:
  - ram_addr/ram_wdata driven from the latched values.
  - ram_we=1 only in the first RAM_ACC cycle, and only for writes.
  - While counter != 0, decrement.
  - At counter==0: for reads capture ram_rdata into cpu_rdata, then go to DONE. State lasts RAM_WAIT+1 cycles.
- PER_REQ:
  - per_req=1 with stable per_addr/per_we/per_wdata.
  - per_ack=1: capture per_rdata on reads, go to DONE, err=0.
  - Otherwise decrement the counter. Reaching 0 with no ack: go to DONE, err=1, cpu_rdata unchanged.
  - Ack in the same cycle the counter hits 0 counts as success.
  - per_ack outside PER_REQ is ignored.
- DONE: mio_ready=1 and bus_err=err for exactly one cycle, then IDLE. A request present in DONE is not re-accepted; IDLE samples on the next cycle.
- Latency from the accepting edge to mio_ready high:
  - RAM: RAM_WAIT+2 cycles.
  - Peripheral: (cycles until ack)+1.
  - Error: 1 cycle.
- cpu_rdata holds its last read value; writes and errors never change it.
- Consecutive requests: minimum spacing 1 IDLE cycle between a mio_ready and the next accept.
- cpu_mio=0 with mem_read/mem_write set: ignored.

Test Plan:
- Reset, then RAM_WAIT=1. Read addr=0x0000_0010 with RAM word 4 = 0x1234_5678 → ram_addr=4, mio_ready high on 3rd cycle after accept, cpu_rdata=0x1234_5678, bus_err=0.
- Write addr=0x0000_0008, data 0xCAFE_F00D → ram_we high exactly one cycle with ram_addr=2 and ram_wdata=0xCAFE_F00D; mio_ready after 3 cycles; cpu_rdata unchanged.
- Peripheral read addr=0xF000_0024, per_ack after 4 cycles with per_rdata=0xA5A5_0001 → per_addr=0x09, per_we=0, per_req high 4 cycles, then mio_ready with cpu_rdata=0xA5A5_0001, bus_err=0.
- Peripheral write, no ack, PER_TIMEOUT=16 → per_req drops after 16 cycles, mio_ready with bus_err=1; previous cpu_rdata retained.
- Illegal requests:
  - mem_read=mem_write=1 → mio_ready next cycle with bus_err=1, no ram_we/per_req.
  - addr=0x0000_0006 → same error response.
- Reset asserted mid-PER_REQ → per_req low immediately, state IDLE, no mio_ready. A subsequent RAM read completes normally.
